// File: rtl/ones_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ones_pkg
//  Description : Shared constants and state type for the ones' complement
//                checksum accumulator.
//  Revision    : 1.0 - initial release
// ============================================================================
package ones_pkg;

    // Default data width of the accumulator datapath
    localparam int c_WIDTH_DEFAULT = 8;

    // Width of the packet word counter and its saturation value
    localparam int         c_LEN_W   = 8;
    localparam logic [7:0] c_LEN_MAX = 8'hFF;

    // Accumulator FSM: collecting words, or holding a finished result
    typedef enum logic [0:0] {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

endpackage : ones_pkg
`default_nettype wire

// File: rtl/ones_add.sv
`default_nettype none
// ============================================================================
//  Module      : ones_add
//  Description : Combinational ones' complement adder with end-around carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module ones_add
    import ones_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH:0] w_total;

    // Full-width add, then fold the carry back into bit 0. The folded add
    // cannot carry again, so the upper bit is simply dropped.
    always_comb begin
        w_total = {1'b0, a} + {1'b0, b};
        sum     = w_total[WIDTH-1:0] + {{(WIDTH-1){1'b0}}, w_total[WIDTH]};
    end

endmodule : ones_add
`default_nettype wire

// File: rtl/ones_checksum_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ones_checksum_acc
//  Description : Streams packet words in, accumulates their ones' complement
//                sum and presents the complemented checksum plus a saturating
//                word count once the last word of the packet is taken.
//  Revision    : 1.0 - initial release
// ============================================================================
module ones_checksum_acc
    import ones_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_last,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic [c_LEN_W-1:0] out_len
);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sum;
    logic [c_LEN_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_out_sum;
    logic [c_LEN_W-1:0] r_out_len;

    logic [WIDTH-1:0]   w_sum_next;
    logic [c_LEN_W-1:0] w_cnt_next;
    logic               w_accept;

    // Running sum plus the incoming word, with end-around carry
    ones_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a   (r_sum),
        .b   (in_data),
        .sum (w_sum_next)
    );

    // Handshake and counter increment derived from the current state
    always_comb begin
        in_ready   = (r_state == ACC);
        out_valid  = (r_state == DONE);
        w_accept   = in_valid && (r_state == ACC);
        w_cnt_next = (r_cnt == c_LEN_MAX) ? r_cnt : r_cnt + 8'd1;
    end

    // Next-state: leave ACC on the last accepted word, leave DONE on consume
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACC:     if (w_accept && in_last) w_state_next = DONE;
            DONE:    if (out_ready)           w_state_next = ACC;
            default: w_state_next = ACC;
        endcase
    end

    // State register; reset always returns to collecting
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ACC;
        else        r_state <= w_state_next;
    end

    // Accumulator, counter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sum     <= '0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_out_len <= '0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept) begin
                        r_sum <= w_sum_next;
                        r_cnt <= w_cnt_next;
                        if (in_last) begin
                            r_out_sum <= ~w_sum_next;
                            r_out_len <= w_cnt_next;
                        end
                    end
                end
                DONE: begin
                    // Result stays put; clear the accumulator for the next packet
                    if (out_ready) begin
                        r_sum <= '0;
                        r_cnt <= '0;
                    end
                end
                default: begin
                    r_sum <= '0;
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign out_sum = r_out_sum;
    assign out_len = r_out_len;

endmodule : ones_checksum_acc
`default_nettype wire

// File: doc/ones_checksum_acc.md
ONES_CHECKSUM_ACC -- requirements
Module: ones_checksum_acc

Interface
REQ-001 The block SHALL have a parameter WIDTH, default 8, setting the data width in bits.
REQ-002 The block SHALL have the port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-004 The block SHALL have the port in_valid, input, 1 bit, meaning in_data/in_last are valid.
REQ-005 The block SHALL have the port in_data, input, WIDTH bits, the data word to accumulate.
REQ-006 The block SHALL have the port in_last, input, 1 bit, marking the final word of a packet.
REQ-007 The block SHALL have the port in_ready, output, 1 bit, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have the port out_valid, output, 1 bit, meaning the checksum result is valid.
REQ-009 The block SHALL have the port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-010 The block SHALL have the port out_sum, output, WIDTH bits, the ones' complement of the packet's ones' complement sum.
REQ-011 The block SHALL have the port out_len, output, 8 bits, the packet word count, saturating at 255.

Function
REQ-012 The block SHALL be a two-state FSM: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-013 A word SHALL be accepted on any cycle with in_valid && in_ready.
REQ-014 Each accepted word SHALL update the sum with end-around carry: t = sum + in_data (WIDTH+1 bits); sum_next = t[WIDTH-1:0] + t[WIDTH].
REQ-015 Each accepted word SHALL increment the word counter by 1, holding at 255 once reached.
REQ-016 An accepted word with in_last=1 SHALL move the FSM ACC->DONE, with out_sum = ~sum_next and out_len = the count including that word.
REQ-017 out_valid SHALL assert the cycle after the last word is accepted, giving 1-cycle latency.
REQ-018 In DONE, out_sum and out_len SHALL be held stable while out_ready=0.
REQ-019 In DONE, when out_ready=1 the FSM SHALL return to ACC next cycle with sum and counter cleared to 0.
REQ-020 in_valid in DONE SHALL be ignored (no accept, no state change); an upstream word stalls until ACC.
REQ-021 Words with in_valid=0 in ACC SHALL leave sum and counter unchanged.
REQ-022 Sum arithmetic SHALL never exceed WIDTH bits; a second carry is impossible and SHALL not be handled specially.
REQ-023 A single-word packet (first word has in_last=1) SHALL be valid and produce out_len=1.
REQ-024 The all-ones sum (negative zero) SHALL be kept as-is, not normalised to 0.

Reset
REQ-025 When rst_n=0 at a clk edge, the block SHALL set the FSM to ACC, sum=0, counter=0, out_sum=0, out_len=0, out_valid=0, in_ready=1 on the next cycle.
REQ-026 Reset mid-packet or in DONE SHALL discard partial or pending results without emitting out_valid.
REQ-027 The block SHALL accept no word on a cycle with rst_n=0.

Structure
REQ-028 A shared package ones_pkg SHALL hold the WIDTH default constant and the state enum type {ACC, DONE}.
REQ-029 The end-around-carry addition SHALL be a combinational sub-module ones_add (a, b -> sum, WIDTH-parameterised), instantiated once.
REQ-030 Registers SHALL be the FSM state, sum, counter, out_sum and out_len only.

Verification
REQ-031 The bench SHALL drive words 0x01, 0x02(last) and check out_sum=0xFC, out_len=2, valid one cycle after the last accept.
REQ-032 The bench SHALL drive 0x80, 0x80(last) and check end-around carry: sum 0x01, out_sum=0xFE.
REQ-033 The bench SHALL drive 0xFF, 0xFF(last) and check sum 0xFF, out_sum=0x00, then a single word 0x00(last) giving out_sum=0xFF, out_len=1.
REQ-034 The bench SHALL hold out_ready=0 for 3 cycles in DONE with in_valid=1, and check that out_sum/out_len stay stable, in_ready=0 and no word is consumed; after out_ready=1 the next packet starts from sum 0.
REQ-035 The bench SHALL pulse rst_n=0 after 2 of 4 words and then send 0x05(last), checking out_sum=0xFA, out_len=1 and no earlier out_valid.
REQ-036 The bench SHALL send 300 words of 0x00 then last, and check out_len=255 and out_sum=0xFF.
